// File: rtl/xk_power_accum.sv
`timescale 1ns/1ps
// xk_power_accum
//   Accumulates |X[k]|^2 over ACC_LEN consecutive FFT frames and streams the
//   summed power spectrum out once per ACC_LEN input frames.
//
// Ports
//   clk                     sole clock, rising edge
//   rst                     synchronous active-low reset
//   s_axis_*                input spectrum, SAMP_PER_CLK lanes of {im,re}, lane 0 = lowest bin
//   m_axis_tdata/valid/last output power, SAMP_PER_CLK lanes of ACC_W bits
//   m_axis_tready           downstream backpressure; stalls the whole pipeline
//   m_axis_tuser            dump index, +1 per output frame
//   event_tlast_unexpected  pulse: input tlast seen before the last word of a frame
//   event_tlast_missing     pulse: input tlast absent on the last word of a frame
//   event_acc_saturate      pulse: at least one lane of a beat clipped to all-ones
//
// State table
//   CLEAR | zero all accumulator words, one per cycle; input not accepted
//   ACCUM | add incoming power into the accumulator, nothing output
//   DUMP  | last frame of the set: emit acc+p, write zero back

module xk_power_accum #(
   parameter int FFT_LEN      = 32,
   parameter int SAMP_PER_CLK = 2,
   parameter int IN_W         = 25,
   parameter int ACC_W        = 64,
   parameter int ACC_LEN      = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [SAMP_PER_CLK*2*IN_W-1:0] s_axis_tdata,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tlast,
   output logic [SAMP_PER_CLK*ACC_W-1:0]  m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic [15:0]                    m_axis_tuser,
   output logic                           event_tlast_unexpected,
   output logic                           event_tlast_missing,
   output logic                           event_acc_saturate
);

   localparam int WORDS = FFT_LEN / SAMP_PER_CLK;
   localparam int W_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int F_W   = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam int P_W   = 2*IN_W + 1;
   localparam int D_W   = SAMP_PER_CLK * ACC_W;

   localparam logic [W_W-1:0] W_LAST = W_W'(WORDS - 1);
   localparam logic [F_W-1:0] F_LAST = F_W'(ACC_LEN - 1);
   // frame index at whose wrap the next frame becomes the dump frame
   localparam logic [F_W-1:0] F_PRE  = F_W'((ACC_LEN > 1) ? ACC_LEN - 2 : 0);

   typedef enum logic [1:0] {CLEAR, ACCUM, DUMP} state_t;

   state_t                   state, state_nxt;
   logic [W_W-1:0]           clr_cnt;
   logic [W_W-1:0]           w_cnt;
   logic [F_W-1:0]           f_cnt;
   logic [15:0]              dump_cnt;

   logic                     advance;
   logic                     accept;
   logic                     w_wrap;

   logic [D_W-1:0]           ram [WORDS];
   logic                     ram_we;
   logic [W_W-1:0]           ram_addr;
   logic [D_W-1:0]           ram_wdata;

   logic [SAMP_PER_CLK*P_W-1:0] sq_all;
   logic [D_W-1:0]           sat_sum;
   logic [SAMP_PER_CLK-1:0]  lane_sat;

   // stage 1: squared input + accumulator read
   logic                     s1_valid, s1_dump, s1_last;
   logic [W_W-1:0]           s1_addr;
   logic [SAMP_PER_CLK*P_W-1:0] s1_p;
   logic [D_W-1:0]           s1_rd;
   // stage 2: saturated sum (only dump beats carry a valid)
   logic                     s2_valid, s2_last;
   logic [D_W-1:0]           s2_data;

   assign advance       = !m_axis_tvalid || m_axis_tready;
   assign s_axis_tready = rst && (state != CLEAR) && advance;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign w_wrap        = accept && (w_cnt == W_LAST);

   for (genvar k = 0; k < SAMP_PER_CLK; k++) begin : g_lane
      logic signed [IN_W-1:0]   re_v, im_v;
      logic signed [2*IN_W-1:0] re_x, im_x, re_sq, im_sq;
      logic [ACC_W:0]           sum_full;

      assign re_v  = s_axis_tdata[k*2*IN_W +: IN_W];
      assign im_v  = s_axis_tdata[k*2*IN_W+IN_W +: IN_W];
      assign re_x  = (2*IN_W)'(re_v);
      assign im_x  = (2*IN_W)'(im_v);
      assign re_sq = re_x * re_x;
      assign im_sq = im_x * im_x;
      // each square is non-negative and <= 2^(2*IN_W-2), so the sum is exact in P_W bits
      assign sq_all[k*P_W +: P_W] = {1'b0, re_sq} + {1'b0, im_sq};

      assign sum_full = {1'b0, s1_rd[k*ACC_W +: ACC_W]} + (ACC_W+1)'(s1_p[k*P_W +: P_W]);
      assign sat_sum[k*ACC_W +: ACC_W] = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
      assign lane_sat[k] = sum_full[ACC_W];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR: begin
            if (clr_cnt == W_LAST) begin
               if (ACC_LEN == 1) state_nxt = DUMP;
               else              state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (w_wrap && (f_cnt == F_PRE)) state_nxt = DUMP;
         end
         DUMP: begin
            if (w_wrap) begin
               if (ACC_LEN == 1) state_nxt = DUMP;
               else              state_nxt = ACCUM;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // CLEAR never overlaps a valid stage-1 beat: reset empties the pipeline first
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = s1_addr;
      ram_wdata = sat_sum;
      if (state == CLEAR) begin
         ram_we    = rst;
         ram_addr  = clr_cnt;
         ram_wdata = '0;
      end else if (advance && s1_valid) begin
         ram_we    = rst;
         if (s1_dump) ram_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      if (advance) begin
         s1_p    <= sq_all;
         s1_rd   <= ram[w_cnt];
         s2_data <= sat_sum;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state                  <= CLEAR;
         clr_cnt                <= '0;
         w_cnt                  <= '0;
         f_cnt                  <= '0;
         dump_cnt               <= '0;
         s1_valid               <= 1'b0;
         s1_dump                <= 1'b0;
         s1_last                <= 1'b0;
         s1_addr                <= '0;
         s2_valid               <= 1'b0;
         s2_last                <= 1'b0;
         m_axis_tvalid          <= 1'b0;
         m_axis_tlast           <= 1'b0;
         m_axis_tdata           <= '0;
         m_axis_tuser           <= '0;
         event_tlast_unexpected <= 1'b0;
         event_tlast_missing    <= 1'b0;
         event_acc_saturate     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) clr_cnt <= clr_cnt + W_W'(1);
         else                clr_cnt <= '0;

         if (accept) begin
            if (w_cnt == W_LAST) begin
               w_cnt <= '0;
               if (f_cnt == F_LAST) f_cnt <= '0;
               else                 f_cnt <= f_cnt + F_W'(1);
            end else begin
               w_cnt <= w_cnt + W_W'(1);
            end
         end

         // the word counter defines framing; input tlast is only checked against it
         event_tlast_unexpected <= accept && s_axis_tlast && (w_cnt != W_LAST);
         event_tlast_missing    <= accept && !s_axis_tlast && (w_cnt == W_LAST);
         event_acc_saturate     <= advance && s1_valid && (|lane_sat);

         if (advance) begin
            s1_valid      <= accept;
            s1_dump       <= (state == DUMP);
            s1_last       <= (w_cnt == W_LAST);
            s1_addr       <= w_cnt;
            s2_valid      <= s1_valid && s1_dump;
            s2_last       <= s1_last;
            m_axis_tvalid <= s2_valid;
            m_axis_tlast  <= s2_valid && s2_last;
            m_axis_tdata  <= s2_data;
            m_axis_tuser  <= dump_cnt;
            if (s2_valid && s2_last) dump_cnt <= dump_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_xk_power_accum.sv
`timescale 1ns/1ps
// Bench for xk_power_accum: a table of spectrum scenarios (each preceded by a
// reset) plus a mid-frame reset sequence. A second instance with the narrowest
// legal accumulator sees the same stimulus to exercise saturation.

module tb_xk_power_accum;

   localparam int IN_W    = 25;
   localparam int ACC_W   = 64;
   localparam int SAT_W   = 2*IN_W + 1;
   localparam int WORDS   = 16;
   localparam int ACC_LEN = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [99:0]  s_tdata;
   logic         s_tvalid, s_tlast, m_tready;
   logic         s_tready, m_tvalid, m_tlast, ev_unexp, ev_miss, ev_sat;
   logic [127:0] m_tdata;
   logic [15:0]  m_tuser;
   logic         sx_tready, sx_tvalid, sx_tlast, sx_unexp, sx_miss, sx_sat;
   logic [101:0] sx_tdata;
   logic [15:0]  sx_tuser;

   always #5 clk = ~clk;

   xk_power_accum u_dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
      .m_axis_tuser(m_tuser),
      .event_tlast_unexpected(ev_unexp), .event_tlast_missing(ev_miss), .event_acc_saturate(ev_sat)
   );

   xk_power_accum #(.ACC_W(SAT_W)) u_sat (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(sx_tready), .s_axis_tlast(s_tlast),
      .m_axis_tdata(sx_tdata), .m_axis_tvalid(sx_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(sx_tlast),
      .m_axis_tuser(sx_tuser),
      .event_tlast_unexpected(sx_unexp), .event_tlast_missing(sx_miss), .event_acc_saturate(sx_sat)
   );

   typedef struct {
      logic [127:0] d;
      logic         l;
      logic [15:0]  u;
   } beat_t;

   typedef struct {
      int              re;
      int              im;
      int              bin;     // -1: every bin carries (re,im)
      int              nfr;
      bit              rnd;     // random downstream ready
      bit              anom;    // frame 0: tlast at word 5, none at word 15
      longint unsigned exp;     // power sum per active bin
      int              sat_ev;  // expected saturate pulses on the narrow instance
   } row_t;

   row_t  rows[8];
   beat_t q_main[$];
   beat_t q_sat[$];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   bit rnd_mode = 1'b0;
   int cnt_unexp, cnt_miss, cnt_sat, cntx_unexp, cntx_miss, cntx_sat;
   int first_out_cyc = -1;
   int lat_pres = -1;
   logic         p_stall = 1'b0, px_stall = 1'b0;
   logic [145:0] p_snap;
   logic [119:0] px_snap;

   always @(posedge clk) cyc = cyc + 1;

   always @(posedge clk) begin
      #1;
      m_tready = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         p_stall  = 1'b0;
         px_stall = 1'b0;
      end else begin
         if (p_stall) begin
            n_cmp++;
            if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== p_snap) begin
               n_fail++;
               $display("FAIL stall_hold_main: got %h want %h", {m_tvalid, m_tlast, m_tuser, m_tdata}, p_snap);
            end
         end
         if (px_stall) begin
            n_cmp++;
            if ({sx_tvalid, sx_tlast, sx_tuser, sx_tdata} !== px_snap) begin
               n_fail++;
               $display("FAIL stall_hold_sat: got %h want %h", {sx_tvalid, sx_tlast, sx_tuser, sx_tdata}, px_snap);
            end
         end
         p_stall  = m_tvalid && !m_tready;
         p_snap   = {m_tvalid, m_tlast, m_tuser, m_tdata};
         px_stall = sx_tvalid && !m_tready;
         px_snap  = {sx_tvalid, sx_tlast, sx_tuser, sx_tdata};
         if (m_tvalid && m_tready) begin
            q_main.push_back('{d: m_tdata, l: m_tlast, u: m_tuser});
            if (first_out_cyc < 0) first_out_cyc = cyc;
         end
         if (sx_tvalid && m_tready) q_sat.push_back('{d: {26'b0, sx_tdata}, l: sx_tlast, u: sx_tuser});
         if (ev_unexp) cnt_unexp++;
         if (ev_miss)  cnt_miss++;
         if (ev_sat)   cnt_sat++;
         if (sx_unexp) cntx_unexp++;
         if (sx_miss)  cntx_miss++;
         if (sx_sat)   cntx_sat++;
      end
   end

   task automatic do_reset();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      rst      = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (s_tready !== 1'b0 || sx_tready !== 1'b0) begin
         n_fail++;
         $display("FAIL tready_in_reset: got %b/%b want 0/0", s_tready, sx_tready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tuser !== 16'd0 ||
          ev_unexp !== 1'b0 || ev_miss !== 1'b0 || ev_sat !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b l=%b d=%h u=%0d ev=%b%b%b want all zero",
                  m_tvalid, m_tlast, m_tdata, m_tuser, ev_unexp, ev_miss, ev_sat);
      end
      rst = 1'b1;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (s_tready) break;
         n++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_beats(input int re, input int im, input int bin, input int nbeats, input bit anom);
      for (int i = 0; i < nbeats; i++) begin
         int          b, fr, pc;
         logic [99:0] d;
         bit          hs;
         b  = i % WORDS;
         fr = i / WORDS;
         d  = '0;
         for (int k = 0; k < 2; k++) begin
            if (bin < 0 || bin == 2*b + k) begin
               d[k*50 +: 25]      = 25'(re);
               d[k*50 + 25 +: 25] = 25'(im);
            end
         end
         s_tdata  = d;
         s_tlast  = (anom && fr == 0) ? (b == 5) : (b == WORDS - 1);
         s_tvalid = 1'b1;
         hs = 1'b0;
         pc = 0;
         for (int t = 0; t < 200 && !hs; t++) begin
            @(negedge clk);
            hs = s_tready;
            pc = cyc;
            @(posedge clk);
            #1;
         end
         if (!hs) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: beat %0d not accepted within 200 cycles", i);
            break;
         end
         if (i == (ACC_LEN - 1) * WORDS) lat_pres = pc;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain(input int nexp);
      for (int t = 0; t < 3000 && (q_main.size() < nexp || q_sat.size() < nexp); t++) @(posedge clk);
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic check_out(input longint unsigned ev, input int bin, input int nexp);
      longint unsigned sat_max, evs;
      sat_max = (64'd1 << SAT_W) - 64'd1;
      evs = (ev > sat_max) ? sat_max : ev;
      n_cmp++;
      if (q_main.size() != nexp) begin
         n_fail++;
         $display("FAIL beat_count_main: got %0d want %0d", q_main.size(), nexp);
      end
      n_cmp++;
      if (q_sat.size() != nexp) begin
         n_fail++;
         $display("FAIL beat_count_sat: got %0d want %0d", q_sat.size(), nexp);
      end
      for (int i = 0; i < nexp; i++) begin
         logic [127:0] em, es;
         logic         el;
         logic [15:0]  eu;
         em = '0;
         es = '0;
         for (int k = 0; k < 2; k++) begin
            if (bin < 0 || bin == 2*(i % WORDS) + k) begin
               em[k*ACC_W +: ACC_W] = ev;
               es[k*SAT_W +: SAT_W] = SAT_W'(evs);
            end
         end
         el = ((i % WORDS) == WORDS - 1);
         eu = 16'(i / WORDS);
         if (i < q_main.size()) begin
            n_cmp++;
            if (q_main[i].d !== em || q_main[i].l !== el || q_main[i].u !== eu) begin
               n_fail++;
               $display("FAIL beat_main[%0d]: got d=%h l=%b u=%0d want d=%h l=%b u=%0d",
                        i, q_main[i].d, q_main[i].l, q_main[i].u, em, el, eu);
            end
         end
         if (i < q_sat.size()) begin
            n_cmp++;
            if (q_sat[i].d !== es || q_sat[i].l !== el || q_sat[i].u !== eu) begin
               n_fail++;
               $display("FAIL beat_sat[%0d]: got d=%h l=%b u=%0d want d=%h l=%b u=%0d",
                        i, q_sat[i].d, q_sat[i].l, q_sat[i].u, es, el, eu);
            end
         end
      end
   endtask

   task automatic run(input row_t r);
      int n, nexp, eu;
      rnd_mode = r.rnd;
      do_reset();
      wait_ready(n);
      n_cmp++;
      if (n != WORDS) begin
         n_fail++;
         $display("FAIL clear_cycles: got %0d want %0d", n, WORDS);
      end
      q_main.delete();
      q_sat.delete();
      cnt_unexp = 0; cnt_miss = 0; cnt_sat = 0;
      cntx_unexp = 0; cntx_miss = 0; cntx_sat = 0;
      first_out_cyc = -1;
      lat_pres = -1;
      send_beats(r.re, r.im, r.bin, r.nfr * WORDS, r.anom);
      nexp = (r.nfr / ACC_LEN) * WORDS;
      drain(nexp);
      rnd_mode = 1'b0;
      check_out(r.exp, r.bin, nexp);
      eu = r.anom ? 1 : 0;
      n_cmp++;
      if (cnt_unexp != eu || cnt_miss != eu || cntx_unexp != eu || cntx_miss != eu) begin
         n_fail++;
         $display("FAIL tlast_events: got unexp=%0d/%0d miss=%0d/%0d want %0d each",
                  cnt_unexp, cntx_unexp, cnt_miss, cntx_miss, eu);
      end
      n_cmp++;
      if (cnt_sat != 0 || cntx_sat != r.sat_ev) begin
         n_fail++;
         $display("FAIL sat_events: got main=%0d narrow=%0d want 0/%0d", cnt_sat, cntx_sat, r.sat_ev);
      end
      if (!r.rnd) begin
         n_cmp++;
         if (first_out_cyc - lat_pres != 3) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles want 3", first_out_cyc - lat_pres);
         end
      end
   endtask

   initial begin
      int n;
      //           re         im         bin nfr rnd anom exp                       sat_ev
      rows[0] = '{256,       0,         2,  4,  1'b0, 1'b0, 64'd262144,              0};
      rows[1] = '{3,         4,         -1, 8,  1'b0, 1'b0, 64'd100,                 0};
      rows[2] = '{3,         4,         -1, 8,  1'b1, 1'b0, 64'd100,                 0};
      rows[3] = '{-7,        5,         -1, 4,  1'b1, 1'b0, 64'd296,                 0};
      rows[4] = '{-1000,     1000,      31, 4,  1'b0, 1'b0, 64'd8000000,             0};
      rows[5] = '{16777215,  16777215,  0,  4,  1'b0, 1'b0, 64'd2251799545249800,    0};
      rows[6] = '{-16777216, -16777216, -1, 4,  1'b0, 1'b0, 64'd2251799813685248,    16};
      rows[7] = '{3,         4,         -1, 4,  1'b0, 1'b1, 64'd100,                 0};

      rst      = 1'b0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = '0;
      m_tready = 1'b1;
      @(posedge clk);
      #1;

      foreach (rows[i]) run(rows[i]);

      // partial sums from 1.5 frames must vanish after a one-cycle reset mid-frame
      rnd_mode = 1'b0;
      do_reset();
      wait_ready(n);
      send_beats(3, 4, -1, WORDS + 7, 1'b0);
      run(rows[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
